// File: rtl/ps2_cmd_ctrl.sv
// ps2_cmd_ctrl: host-side sequencer for a PS/2 transceiver pair.
//
// Takes one-byte device commands from the CPU, strobes them into the transmitter, waits for
// transmit completion and the device ACK (0xFA), retries on RESEND (0xFE) and reports done or
// error. Every received frame is checked (start/stop/odd parity). Unsolicited valid bytes are
// buffered in a show-ahead FIFO for the CPU.
//
// Optional feature, macro PS2_INIT_SEQ_EN: after reset the block sends 0xFF, expects 0xFA and
// then the BAT result 0xAA before raising init_done. Undefined: init_done is tied high and the
// FSM starts in IDLE.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_data  command request and byte; cmd_ready high in IDLE
//   cmd_done, cmd_err   one-cycle completion / failure pulses
//   ps2_din, ps2_wr     byte and one-cycle strobe to the transmitter
//   ps2_dout            received frame {stop, parity, data[7:0], start}
//   ps2_rx_done         frame-received tick
//   ps2_tx_done         transmit-complete tick
//   sc_valid, sc_data   FIFO not empty, FIFO head byte
//   sc_rd               pop FIFO head (ignored when empty)
//   sc_ovf              sticky overflow flag, cleared by sc_rd
//   frame_err           one-cycle pulse when a bad frame is dropped
//   init_done           device initialised
module ps2_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    output logic        cmd_done,
    output logic        cmd_err,
    output logic [7:0]  ps2_din,
    output logic        ps2_wr,
    input  logic [10:0] ps2_dout,
    input  logic        ps2_rx_done,
    input  logic        ps2_tx_done,
    output logic        sc_valid,
    output logic [7:0]  sc_data,
    input  logic        sc_rd,
    output logic        sc_ovf,
    output logic        frame_err,
    output logic        init_done
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW   = AW + 1;

    // Watchdog fires on the edge where the count would reach TIMEOUT_CYCLES, so the error
    // pulse lands exactly TIMEOUT_CYCLES edges after the watchdog was cleared.
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RT_W-1:0] RT_MAX   = RT_W'(MAX_RETRY);
    localparam logic [CW-1:0]   CNT_FULL = CW'(FIFO_DEPTH);

    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SEND     = 3'd1;
    localparam logic [2:0] S_WAIT_TX  = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
`ifdef PS2_INIT_SEQ_EN
    localparam logic [2:0] S_INIT_SEND = 3'd4;
    localparam logic [2:0] S_INIT_TX   = 3'd5;
    localparam logic [2:0] S_INIT_ACK  = 3'd6;
    localparam logic [2:0] S_INIT_BAT  = 3'd7;
    localparam logic [2:0] S_RESET     = S_INIT_SEND;

    localparam logic [7:0] BYTE_RESET    = 8'hFF;
    localparam logic [7:0] BYTE_BAT_OK   = 8'hAA;
    localparam logic [7:0] BYTE_BAT_FAIL = 8'hFC;
`else
    localparam logic [2:0] S_RESET = S_IDLE;
`endif

    logic [2:0]      state_q, state_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [RT_W-1:0] retry_q, retry_d;
    logic [7:0]      din_q, din_d;
    logic            done_set, err_set, push_req;
    logic            cmd_done_q, cmd_err_q, frame_err_q;

    // Frame check: start low, stop high, odd parity over data plus parity bit.
    logic       frame_ok, rx_ok;
    logic [7:0] rx_byte;

    assign rx_byte  = ps2_dout[8:1];
    assign frame_ok = !ps2_dout[0] && ps2_dout[10] && (^ps2_dout[9:1]);
    assign rx_ok    = ps2_rx_done && frame_ok;

`ifdef PS2_INIT_SEQ_EN
    logic init_q, init_d;
    // Low for the first cycle after reset so the reset-time strobe stays 0 while 0xFF loads.
    logic boot_q, boot_d;
`endif

    always_comb begin
        state_d  = state_q;
        wdog_d   = wdog_q + WD_W'(1);
        retry_d  = retry_q;
        din_d    = din_q;
        done_set = 1'b0;
        err_set  = 1'b0;
        push_req = 1'b0;
`ifdef PS2_INIT_SEQ_EN
        init_d   = init_q;
        boot_d   = boot_q;
`endif
        case (state_q)
            S_IDLE: begin
                wdog_d   = '0;
                push_req = rx_ok;
                if (cmd_valid) begin
                    din_d   = cmd_data;
                    retry_d = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                wdog_d   = '0;
                push_req = rx_ok;
                state_d  = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                push_req = rx_ok;
                if (ps2_tx_done) begin
                    wdog_d  = '0;
                    state_d = S_WAIT_ACK;
                end else if (wdog_q == WD_LAST) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_ACK: begin
                if (rx_ok && rx_byte == BYTE_ACK) begin
                    done_set = 1'b1;
                    state_d  = S_IDLE;
                end else if (rx_ok && rx_byte == BYTE_RESEND) begin
                    if (retry_q < RT_MAX) begin
                        retry_d = retry_q + RT_W'(1);
                        state_d = S_SEND;
                    end else begin
                        err_set = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    // Unrelated traffic keeps flowing to the CPU; it does not extend the wait.
                    push_req = rx_ok;
                    if (wdog_q == WD_LAST) begin
                        err_set = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`ifdef PS2_INIT_SEQ_EN
            S_INIT_SEND: begin
                wdog_d = '0;
                if (!boot_q) begin
                    boot_d = 1'b1;
                    din_d  = BYTE_RESET;
                end else begin
                    state_d = S_INIT_TX;
                end
            end
            S_INIT_TX: begin
                if (ps2_tx_done) begin
                    wdog_d  = '0;
                    state_d = S_INIT_ACK;
                end else if (wdog_q == WD_LAST) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_INIT_ACK: begin
                if (rx_ok && rx_byte == BYTE_ACK) begin
                    wdog_d  = '0;
                    state_d = S_INIT_BAT;
                end else if (rx_ok && rx_byte == BYTE_RESEND) begin
                    if (retry_q < RT_MAX) begin
                        retry_d = retry_q + RT_W'(1);
                        state_d = S_INIT_SEND;
                    end else begin
                        err_set = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (wdog_q == WD_LAST) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_INIT_BAT: begin
                if (rx_ok && rx_byte == BYTE_BAT_OK) begin
                    init_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (rx_ok && rx_byte == BYTE_BAT_FAIL) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end else if (wdog_q == WD_LAST) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                wdog_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET;
            wdog_q      <= '0;
            retry_q     <= '0;
            din_q       <= '0;
            cmd_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            retry_q     <= retry_d;
            din_q       <= din_d;
            cmd_done_q  <= done_set;
            cmd_err_q   <= err_set;
            frame_err_q <= ps2_rx_done && !frame_ok;
        end
    end

`ifdef PS2_INIT_SEQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
            boot_q <= 1'b0;
        end else begin
            init_q <= init_d;
            boot_q <= boot_d;
        end
    end

    assign init_done = init_q;
    assign ps2_wr    = (state_q == S_SEND) || ((state_q == S_INIT_SEND) && boot_q);
`else
    assign init_done = 1'b1;
    assign ps2_wr    = (state_q == S_SEND);
`endif

    assign cmd_ready = (state_q == S_IDLE);
    assign cmd_done  = cmd_done_q;
    assign cmd_err   = cmd_err_q;
    assign ps2_din   = din_q;
    assign frame_err = frame_err_q;

    // Receive FIFO: pointers wrap modulo FIFO_DEPTH, occupancy has one extra bit.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          fifo_empty, fifo_full, do_pop, do_push;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_FULL);
    assign do_pop     = sc_rd && !fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push    = push_req && (!fifo_full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
            if (push_req && !do_push) begin
                ovf_q <= 1'b1;
            end else if (sc_rd) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= rx_byte;
        end
    end

    assign sc_valid = !fifo_empty;
    assign sc_data  = fifo_empty ? 8'h00 : mem[rd_q];
    assign sc_ovf   = ovf_q;

endmodule
